imem_fetch_unit: RTL

Synthesizable instruction-memory responder for the out-of-order `cpu` fetch port, replacing the behavioural one-request-at-a-time fetch model.
- Holds a programmable instruction memory and accepts pipelined `(fetch_id, fetch_pc)` requests.
- Returns decoded instruction fields, in order, through a credit-limited response FIFO.
- Adds configurable read latency, multiple outstanding fetches, flush, out-of-range detection and a run-time last-PC marker.

---
 rtl/imem_fetch_unit.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: programmable instruction memory with pipelined, credit-limited fetch.
// Optional feature macro IFETCH_STATS_EN adds saturating fetch/stall counters.
module imem_fetch_unit #(
    parameter int PC_BIT          = 8,
    parameter int INST_ID_BIT     = 8,
    parameter int OP_BIT          = 3,
    parameter int TAG_ID_BIT      = 2,
    parameter int IMM_BIT         = 4,
    parameter int IMEM_DEPTH      = 32,
    parameter int MEM_LAT         = 1,
    parameter int RESP_FIFO_DEPTH = 4,
    parameter int STAT_BIT        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_vld,
    input  logic [PC_BIT-1:0]      load_addr,
    input  logic [OP_BIT+3*TAG_ID_BIT+IMM_BIT-1:0] load_data,
    input  logic [PC_BIT-1:0]      prog_last_pc,
    input  logic                   flush,
    input  logic                   fetch_vld,
    output logic                   fetch_rdy,
    input  logic [INST_ID_BIT-1:0] fetch_id,
    input  logic [PC_BIT-1:0]      fetch_pc,
    output logic                   inst_vld,
    input  logic                   inst_rdy,
    output logic [INST_ID_BIT-1:0] inst_id,
    output logic                   inst_last,
    output logic                   inst_oob,
    output logic [OP_BIT-1:0]      inst_op,
    output logic [TAG_ID_BIT-1:0]  inst_dst_reg,
    output logic [TAG_ID_BIT-1:0]  inst_src_reg1,
    output logic [TAG_ID_BIT-1:0]  inst_src_reg0,
    output logic [IMM_BIT-1:0]     inst_imm
`ifdef IFETCH_STATS_EN
    ,
    output logic [STAT_BIT-1:0]    stat_fetch_cnt,
    output logic [STAT_BIT-1:0]    stat_stall_cnt
`endif
);

    localparam int INST_BIT = OP_BIT + 3 * TAG_ID_BIT + IMM_BIT;
    localparam int MA_W     = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int PTR_W    = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;
    localparam int CNT_W    = PTR_W + 1;
    localparam int OCC_W    = $clog2(RESP_FIFO_DEPTH + MEM_LAT + 1);

    localparam logic [PC_BIT:0]  DEPTH_PC  = (PC_BIT + 1)'(IMEM_DEPTH);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(RESP_FIFO_DEPTH);

    typedef struct packed {
        logic [INST_ID_BIT-1:0] id;
        logic                   last;
        logic                   oob;
        logic [INST_BIT-1:0]    word;
    } ent_t;

    logic [INST_BIT-1:0] mem_q [IMEM_DEPTH];

    logic [MEM_LAT-1:0] pvld_q, pvld_d;
    ent_t               pipe_q [MEM_LAT];
    ent_t               pipe_d [MEM_LAT];

    ent_t               fifo_q [RESP_FIFO_DEPTH];
    ent_t               fifo_d [RESP_FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [OCC_W-1:0]   occ;
    logic               accept;
    logic               push;
    logic               pop;
    logic               load_in_rng;
    logic               fetch_oob;
    ent_t               new_ent;
    ent_t               head;
    logic [PTR_W-1:0]   head_idx;

    // Credit check: everything in flight plus queued must fit the FIFO
    always_comb begin
        occ = OCC_W'(cnt_q);
        for (int i = 0; i < MEM_LAT; i++) begin
            occ = occ + OCC_W'(pvld_q[i]);
        end
        fetch_rdy = !flush && (occ < DEPTH_OCC);
        accept    = fetch_vld && fetch_rdy;
        push      = pvld_q[MEM_LAT-1];
        pop       = inst_vld && inst_rdy;
    end

    // Memory read for a new request; out-of-range PCs yield an all-zero word
    always_comb begin
        load_in_rng  = {1'b0, load_addr} < DEPTH_PC;
        fetch_oob    = {1'b0, fetch_pc} >= DEPTH_PC;
        new_ent.id   = fetch_id;
        new_ent.last = fetch_pc == prog_last_pc;
        new_ent.oob  = fetch_oob;
        new_ent.word = '0;
        if (!fetch_oob) begin
            new_ent.word = mem_q[fetch_pc[MA_W-1:0]];
        end
    end

    // Instruction store write port; read above sees the pre-write word
    always_ff @(posedge clk) begin
        if (load_vld && load_in_rng) begin
            mem_q[load_addr[MA_W-1:0]] <= load_data;
        end
    end

    // Read pipeline advances every cycle; credits guarantee room at the end
    always_comb begin
        pvld_d[0] = accept;
        pipe_d[0] = new_ent;
        for (int i = 1; i < MEM_LAT; i++) begin
            pvld_d[i] = pvld_q[i-1];
            pipe_d[i] = pipe_q[i-1];
        end
        if (flush) begin
            pvld_d = '0;
        end
    end

    // Response FIFO; a flush empties it but a same-cycle pop still retires
    always_comb begin
        for (int i = 0; i < RESP_FIFO_DEPTH; i++) begin
            fifo_d[i] = fifo_q[i];
        end
        if (push && !flush) begin
            fifo_d[wr_ptr_q] = pipe_q[MEM_LAT-1];
        end
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        if (flush) begin
            wr_ptr_d = rd_ptr_d;
            cnt_d    = '0;
        end
    end

    // Control state and FIFO storage; storage is cleared so outputs reset to 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pvld_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < RESP_FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            pvld_q   <= pvld_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < RESP_FIFO_DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    // Pipeline payload needs no reset; its valid bits gate it
    always_ff @(posedge clk) begin
        for (int i = 0; i < MEM_LAT; i++) begin
            pipe_q[i] <= pipe_d[i];
        end
    end

    // Head decode; when empty, show the most recently popped entry
    always_comb begin
        inst_vld      = cnt_q != '0;
        head_idx      = inst_vld ? rd_ptr_q : rd_ptr_q - PTR_W'(1);
        head          = fifo_q[head_idx];
        inst_id       = head.id;
        inst_last     = head.last;
        inst_oob      = head.oob;
        inst_imm      = head.word[IMM_BIT-1:0];
        inst_src_reg0 = head.word[IMM_BIT +: TAG_ID_BIT];
        inst_src_reg1 = head.word[IMM_BIT+TAG_ID_BIT +: TAG_ID_BIT];
        inst_dst_reg  = head.word[IMM_BIT+2*TAG_ID_BIT +: TAG_ID_BIT];
        inst_op       = head.word[IMM_BIT+3*TAG_ID_BIT +: OP_BIT];
    end

`ifdef IFETCH_STATS_EN
    localparam logic [STAT_BIT-1:0] STAT_MAX = '1;

    logic [STAT_BIT-1:0] fcnt_q, fcnt_d;
    logic [STAT_BIT-1:0] scnt_q, scnt_d;

    // Saturating counters; flush leaves them untouched
    always_comb begin
        fcnt_d = fcnt_q;
        scnt_d = scnt_q;
        if (accept && fcnt_q != STAT_MAX) begin
            fcnt_d = fcnt_q + 1'b1;
        end
        if (fetch_vld && !fetch_rdy && scnt_q != STAT_MAX) begin
            scnt_d = scnt_q + 1'b1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcnt_q <= '0;
            scnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
            scnt_q <= scnt_d;
        end
    end

    assign stat_fetch_cnt = fcnt_q;
    assign stat_stall_cnt = scnt_q;
`endif

endmodule
